// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter driving the select lines of a shared 16:1 mux,
// with a bounded per-grant hold so no requester can starve the others.
module mux16_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic        valid,
  output logic        sel0,
  output logic        sel1,
  output logic        sel2,
  output logic        sel3,
  output logic [3:0]  owner
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, owner_n, start, pick_idx;
  logic [7:0] cnt, cnt_n;
  logic [15:0] grant_n;
  logic found, rel;
  // After a release the old owner is searched last, so a timed-out owner only wins when alone.
  assign start = state == IDLE ? ptr : owner + 4'd1;
  assign rel = !req[owner] || cnt == 8'(HOLD_MAX - 1);
  always_comb begin
    found = 1'b0;
    pick_idx = '0;
    for (int k = 15; k >= 0; k--)
      if (req[start + 4'(k)]) begin
        found = 1'b1;
        pick_idx = start + 4'(k);
      end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    cnt_n = cnt + 8'd1;
    grant_n = grant;
    if (state == IDLE || rel) begin
      ptr_n = state == GRANT ? owner + 4'd1 : ptr;
      state_n = found ? GRANT : IDLE;
      owner_n = found ? pick_idx : owner;
      cnt_n = '0;
      grant_n = found ? 16'h1 << pick_idx : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      owner <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      owner <= owner_n;
      grant <= grant_n;
    end
  end
  assign valid = state == GRANT;
  assign {sel3, sel2, sel1, sel0} = owner;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: vector table pushed into a scoreboard at each negedge, checked after the next posedge.
module tb_mux16_rr_arbiter;
  typedef struct {
    logic        rst;
    logic        chk1;
    logic [15:0] req;
    logic [15:0] eg;
    logic [3:0]  eo;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] req = 16'h0;
  logic [15:0] grant8, grant1;
  logic valid8, valid1;
  logic s80, s81, s82, s83, s10, s11, s12, s13;
  logic [3:0] owner8, owner1;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t v;
  int total = 0;
  int bad = 0;
  int step = 0;
  logic [15:0] g;
  logic va;
  logic [3:0] o, s;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .reset(reset), .req(req), .grant(grant8), .valid(valid8),
    .sel0(s80), .sel1(s81), .sel2(s82), .sel3(s83), .owner(owner8)
  );
  mux16_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .grant(grant1), .valid(valid1),
    .sel0(s10), .sel1(s11), .sel2(s12), .sel3(s13), .owner(owner1)
  );

  function automatic void add(input logic r, input logic c, input logic [15:0] rq,
                              input logic [15:0] eg, input logic [3:0] eo);
    vec_t t;
    t.rst = r;
    t.chk1 = c;
    t.req = rq;
    t.eg = eg;
    t.eo = eo;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input int n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      v = sb.pop_front();
      g = v.chk1 ? grant1 : grant8;
      va = v.chk1 ? valid1 : valid8;
      o = v.chk1 ? owner1 : owner8;
      s = v.chk1 ? {s13, s12, s11, s10} : {s83, s82, s81, s80};
      check("grant", step, g, v.eg);
      check("valid", step, {15'h0, va}, {15'h0, v.eg != 16'h0});
      check("owner", step, {12'h0, o}, {12'h0, v.eo});
      check("sel", step, {12'h0, s}, {12'h0, v.eo});
      step++;
    end
  end

  initial begin
    // reset with all requesting, then first grant from ptr 0
    add(1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd0);
    add(1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd0);
    add(1'b0, 1'b0, 16'hFFFF, 16'h0001, 4'd0);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 4'd0);
    // single requester, selects hold after release
    add(1'b1, 1'b0, 16'h0000, 16'h0, 4'd0);
    add(1'b0, 1'b0, 16'h2000, 16'h2000, 4'd13);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 4'd13);
    // rotation and wrap between 0 and 15, 8 cycles each
    add(1'b1, 1'b0, 16'h0000, 16'h0, 4'd0);
    for (int i = 0; i < 24; i++)
      add(1'b0, 1'b0, 16'h8001, ((i / 8) % 2) == 1 ? 16'h8000 : 16'h0001, ((i / 8) % 2) == 1 ? 4'd15 : 4'd0);
    // sole requester times out and is re-granted without a bubble
    add(1'b1, 1'b0, 16'h0000, 16'h0, 4'd0);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 16'h0010, 16'h0010, 4'd4);
    // early release hands to 8, whose hold restarts the full 8 cycles
    add(1'b1, 1'b0, 16'h0000, 16'h0, 4'd0);
    add(1'b0, 1'b0, 16'h0108, 16'h0008, 4'd3);
    add(1'b0, 1'b0, 16'h0108, 16'h0008, 4'd3);
    add(1'b0, 1'b0, 16'h0100, 16'h0100, 4'd8);
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 16'h0108, 16'h0100, 4'd8);
    add(1'b0, 1'b0, 16'h0108, 16'h0008, 4'd3);
    // reset mid-grant, then one idle cycle before re-grant
    add(1'b1, 1'b0, 16'h0000, 16'h0, 4'd0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 16'h0200, 16'h0200, 4'd9);
    add(1'b1, 1'b0, 16'h0200, 16'h0, 4'd0);
    add(1'b0, 1'b0, 16'h0200, 16'h0200, 4'd9);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 4'd9);
    // HOLD_MAX=1 instance: per-cycle round robin including wrap
    add(1'b1, 1'b1, 16'h0000, 16'h0, 4'd0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b1, 16'h0007, 16'h1 << (i % 3), 4'(i % 3));
    add(1'b0, 1'b1, 16'h8001, 16'h8000, 4'd15);
    add(1'b0, 1'b1, 16'h8001, 16'h0001, 4'd0);
    add(1'b0, 1'b1, 16'h8001, 16'h8000, 4'd15);
    add(1'b0, 1'b1, 16'h0000, 16'h0, 4'd15);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      req = tbl[i].req;
      sb.push_back(tbl[i]);
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    check("drain", step, 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 mux between 16 requesters.
- Each requester i owns mux input line i.
- The block grants one requester at a time and drives the mux select bits sel0..sel3 to the granted index.
- Hold time per grant is bounded so no requester can starve the others; sits directly in front of the 16:1 mux select inputs.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one grant may be held (legal range 1..255).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  16  request vector, bit i = requester i wants the mux
grant  output  16  registered one-hot grant, all-zero when idle
valid  output  1  high while any grant is held (equals OR of grant)
sel0  output  1  select bit 0 (LSB) of granted index, to mux sel0
sel1  output  1  select bit 1 of granted index, to mux sel1
sel2  output  1  select bit 2 of granted index, to mux sel2
sel3  output  1  select bit 3 (MSB) of granted index, to mux sel3
owner  output  4  granted index {sel3,sel2,sel1,sel0}, for debug/checking

Behaviour:
- Clocking and reset: one clock (clk); reset synchronous, active-high.
- On a reset edge:
  - Outputs: grant=0, valid=0, sel0..sel3=0, owner=0.
  - Internal state: ptr=0, cnt=0, state=IDLE.
  - Reset asserted mid-grant drops grant on the next edge; no completion of the hold.
- Internal state:
  - 2-state FSM {IDLE, GRANT}.
  - 4-bit ptr: search start index.
  - 8-bit cnt: cycles held.
  - 4-bit owner.
- Arbitration function pick(req, start):
  - Returns the lowest k in 0..15 such that req[(start+k) mod 16] is 1, and that index.
  - Index arithmetic is modulo 16; 15+1 wraps to 0.
- IDLE:
  - If req==0, stay IDLE.
  - Else pick(req, ptr) → owner; grant[owner]=1, cnt=0, go to GRANT on the next edge.
  - Latency req→grant is 1 cycle.
- GRANT, release condition R = (req[owner]==0) OR (cnt==HOLD_MAX-1).
  - If not R: hold owner, cnt=cnt+1.
  - If R:
    - ptr=owner+1 mod 16.
    - Re-arbitrate in the same cycle with pick(req, owner+1).
    - If any request is found, the new grant appears on the next edge with cnt=0 (no idle bubble), staying in GRANT.
    - Otherwise go to IDLE with grant=0.
  - The current owner, if still requesting after timeout, is searched last, so it is re-granted only when no other requester is pending.
- Requests:
  - A requester dropping req while granted is released in that same evaluation; grant falls on the next edge.
  - req bits of non-owners may toggle freely; only the owner's bit affects hold.
- Outputs:
  - All outputs are registered.
  - {sel3,sel2,sel1,sel0} always equals owner while valid=1.
  - Selects hold their last value when valid=0; consumers must qualify with valid.
  - grant is always zero or one-hot; never more than one bit set.
- HOLD_MAX=1: every grant lasts exactly 1 cycle (pure round-robin per cycle).

Test Plan:
- Reset: drive req=16'hFFFF with reset=1 for 2 cycles → grant=0, valid=0, sel=0. Release reset → next cycle grant=16'h0001, owner=0.
- Single requester: req=16'h2000 from IDLE → 1 cycle later grant=16'h2000, {sel3..sel0}=4'hD. Drop req → grant=0, valid=0 on the next edge.
- Rotation/wrap: HOLD_MAX=8, req=16'h8001, both held high.
  - Sequence of owners is 0 (8 cycles), 15 (8 cycles), 0 ...
  - Handoffs are back-to-back with no valid=0 cycle.
- Timeout with sole requester: req=16'h0010 held high with HOLD_MAX=8 → owner 4 for 8 cycles, then re-granted immediately. valid stays 1 throughout.
- Early release mid-hold: owner=3 with req=16'h0108. Drop req[3] after 2 cycles → next edge owner=8, cnt restarts (8 more cycles max).
- Reset mid-grant: owner=9 at cnt=5, assert reset one cycle → grant=0, ptr=0. With req=16'h0200 after reset, the grant returns to 9 only after 1 IDLE cycle.
